// File: rtl/acq_frame_serializer_if.sv
// rtl/acq_frame_serializer_if.sv - frame handshake and channel word stream bundle
interface acq_frame_serializer_if #(
  parameter int NUM_CH = 22,
  parameter int DW     = 16
);
  logic [NUM_CH*DW-1:0] frame_in;
  logic                 frame_in_valid;
  logic                 frame_in_ready;
  logic [DW-1:0]        data_out;
  logic                 data_out_valid;
  logic [4:0]           ch;
  logic                 frame_done;

  // Frame source and word consumer side
  modport master (
    output frame_in, frame_in_valid,
    input  frame_in_ready, data_out, data_out_valid, ch, frame_done
  );

  // Serializer side
  modport slave (
    input  frame_in, frame_in_valid,
    output frame_in_ready, data_out, data_out_valid, ch, frame_done
  );
endinterface

// File: rtl/acq_frame_serializer.sv
// rtl/acq_frame_serializer.sv - wide acquisition frame to per-channel word stream
module acq_frame_serializer #(
  parameter int NUM_CH = 22,
  parameter int DW     = 16,
  parameter int GAP    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  acq_frame_serializer_if.slave bus,
  output logic                  busy,
  output logic [15:0]           frame_cnt
);
  localparam logic [4:0] LAST_IDX = 5'(NUM_CH - 1);
  localparam logic [7:0] GAP_LD   = 8'(GAP);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t               state_q;
  logic [4:0]           idx_q;
  logic [7:0]           gap_q;
  logic [NUM_CH*DW-1:0] shadow_q;
  logic [DW-1:0]        data_q;
  logic [4:0]           ch_q;
  logic                 valid_q;
  logic                 done_q;
  logic                 busy_q;
  logic [15:0]          cnt_q;

  logic                 last_word;
  logic                 accept;
  logic                 advance;
  logic [4:0]           idx_nxt;
  logic [DW-1:0]        word_nxt;

  // The last word of a frame is the only in-flight cycle that may take a new frame,
  // which is what lets back-to-back frames run without a bubble.
  assign last_word          = (state_q == SEND) && (idx_q == LAST_IDX);
  assign bus.frame_in_ready = en && ((state_q == IDLE) || last_word);
  assign accept             = bus.frame_in_valid && bus.frame_in_ready;
  assign advance            = ((state_q == WAIT) && (gap_q <= 8'd1)) ||
                              ((state_q == SEND) && !last_word && (GAP == 0));
  assign idx_nxt            = idx_q + 5'd1;
  assign word_nxt           = DW'(shadow_q >> (int'(idx_nxt) * DW));

  assign bus.data_out       = data_q;
  assign bus.data_out_valid = valid_q;
  assign bus.ch             = ch_q;
  assign bus.frame_done     = done_q;
  assign busy               = busy_q;
  assign frame_cnt          = cnt_q;

  // Frame sequencer: accept, word emission, inter-word gap and frame counting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= 5'd0;
      gap_q    <= 8'd0;
      shadow_q <= '0;
      data_q   <= '0;
      ch_q     <= 5'd0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= 16'd0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      if (last_word) begin
        cnt_q <= cnt_q + 16'd1;
      end
      if (accept) begin
        // Channel 0 comes straight from the input; later words from the shadow copy.
        shadow_q <= bus.frame_in;
        idx_q    <= 5'd0;
        data_q   <= bus.frame_in[DW-1:0];
        ch_q     <= 5'd0;
        valid_q  <= 1'b1;
        state_q  <= SEND;
        busy_q   <= 1'b1;
      end else if (advance) begin
        idx_q   <= idx_nxt;
        data_q  <= word_nxt;
        ch_q    <= idx_nxt;
        valid_q <= 1'b1;
        done_q  <= (idx_nxt == LAST_IDX);
        state_q <= SEND;
      end else begin
        case (state_q)
          SEND: begin
            if (last_word) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= WAIT;
              gap_q   <= GAP_LD;
            end
          end
          WAIT:    gap_q   <= gap_q - 8'd1;
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_acq_frame_serializer.sv
// tb/tb_acq_frame_serializer.sv - randomized timeline-model bench for acq_frame_serializer
module tb_acq_frame_serializer;
  localparam int NUM_CH = 22;
  localparam int DW     = 16;
  localparam int FW     = NUM_CH * DW;
  localparam int RING   = 256;
  localparam int G0     = 0;
  localparam int G1     = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]          en_d;
  logic [1:0]          valid_d;
  logic [1:0][FW-1:0]  frame_d;

  logic [1:0]          rdy_o, vld_o, done_o, busy_o;
  logic [1:0][DW-1:0]  dat_o;
  logic [1:0][4:0]     ch_o;
  logic [1:0][15:0]    cnt_o;

  acq_frame_serializer_if #(.NUM_CH(NUM_CH), .DW(DW)) if0 ();
  acq_frame_serializer_if #(.NUM_CH(NUM_CH), .DW(DW)) if1 ();

  assign if0.frame_in       = frame_d[0];
  assign if0.frame_in_valid = valid_d[0];
  assign if1.frame_in       = frame_d[1];
  assign if1.frame_in_valid = valid_d[1];
  assign rdy_o[0]  = if0.frame_in_ready;
  assign rdy_o[1]  = if1.frame_in_ready;
  assign vld_o[0]  = if0.data_out_valid;
  assign vld_o[1]  = if1.data_out_valid;
  assign done_o[0] = if0.frame_done;
  assign done_o[1] = if1.frame_done;
  assign dat_o[0]  = if0.data_out;
  assign dat_o[1]  = if1.data_out;
  assign ch_o[0]   = if0.ch;
  assign ch_o[1]   = if1.ch;

  acq_frame_serializer #(.NUM_CH(NUM_CH), .DW(DW), .GAP(G0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en_d[0]), .bus(if0.slave),
    .busy(busy_o[0]), .frame_cnt(cnt_o[0])
  );
  acq_frame_serializer #(.NUM_CH(NUM_CH), .DW(DW), .GAP(G1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en_d[1]), .bus(if1.slave),
    .busy(busy_o[1]), .frame_cnt(cnt_o[1])
  );

  // Reference model: a timeline of expected words per absolute cycle.
  int              gap_of [2] = '{G0, G1};
  int              cyc;
  int              last_cyc [2];
  bit              m_v    [2][RING];
  bit              m_done [2][RING];
  logic [DW-1:0]   m_d    [2][RING];
  logic [4:0]      m_c    [2][RING];
  logic [DW-1:0]   hold_d [2];
  logic [4:0]      hold_c [2];
  logic [15:0]     cnt_m  [2];
  int              strobes [2];
  int              checks = 0;
  int              failures = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", tag, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      last_cyc[i] = -1;
      cnt_m[i]    = 16'd0;
      hold_d[i]   = '0;
      hold_c[i]   = 5'd0;
      for (int s = 0; s < RING; s++) m_v[i][s] = 1'b0;
    end
  endtask

  // One cycle: check registered outputs, check ready, record any accept, advance.
  task automatic step();
    int  s;
    int  t;
    bit  ev;
    bit  rdy_m;
    for (int i = 0; i < 2; i++) begin
      s  = cyc % RING;
      ev = m_v[i][s];
      if (ev) begin
        hold_d[i] = m_d[i][s];
        hold_c[i] = m_c[i][s];
      end
      chk($sformatf("u%0d.valid", i), 32'(vld_o[i]), 32'(ev));
      chk($sformatf("u%0d.data", i), 32'(dat_o[i]), 32'(hold_d[i]));
      chk($sformatf("u%0d.ch", i), 32'(ch_o[i]), 32'(hold_c[i]));
      chk($sformatf("u%0d.done", i), 32'(done_o[i]), 32'(ev && m_done[i][s]));
      chk($sformatf("u%0d.busy", i), 32'(busy_o[i]), 32'(cyc <= last_cyc[i]));
      chk($sformatf("u%0d.cnt", i), 32'(cnt_o[i]), 32'(cnt_m[i]));
      if (vld_o[i]) strobes[i]++;
      if (ev && m_done[i][s]) cnt_m[i] = cnt_m[i] + 16'd1;
      m_v[i][s] = 1'b0;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      rdy_m = en_d[i] && (cyc >= last_cyc[i]);
      chk($sformatf("u%0d.ready", i), 32'(rdy_o[i]), 32'(rdy_m));
      if (rst_n && rdy_m && valid_d[i]) begin
        for (int k = 0; k < NUM_CH; k++) begin
          t = cyc + 1 + k * (gap_of[i] + 1);
          s = t % RING;
          m_v[i][s]    = 1'b1;
          m_d[i][s]    = frame_d[i][k*DW +: DW];
          m_c[i][s]    = 5'(k);
          m_done[i][s] = (k == NUM_CH - 1);
        end
        last_cyc[i] = cyc + 1 + (NUM_CH - 1) * (gap_of[i] + 1);
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int j = 0; j < n; j++) step();
  endtask

  task automatic rand_frame(input int i);
    for (int w = 0; w < FW / 32; w++) frame_d[i][w*32 +: 32] = $urandom();
  endtask

  task automatic ramp_frame(input int i);
    for (int k = 0; k < NUM_CH; k++) frame_d[i][k*DW +: DW] = 16'h1000 + 16'(k);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

  int base0;

  initial begin
    en_d    = 2'b11;
    valid_d = 2'b00;
    frame_d = '0;
    strobes = '{0, 0};
    cyc     = 0;
    model_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    run(3);
    rst_n = 1'b1;
    run(2);

    // Same ramp frame into the GAP=0 and GAP=3 instances
    ramp_frame(0);
    ramp_frame(1);
    valid_d = 2'b11;
    step();
    valid_d = 2'b00;
    frame_d = '0;
    run(95);
    chk("single.strobes0", 32'(strobes[0]), 32'd22);
    chk("single.strobes1", 32'(strobes[1]), 32'd22);
    chk("single.cnt0", 32'(cnt_o[0]), 32'd1);
    chk("single.cnt1", 32'(cnt_o[1]), 32'd1);

    // Back-to-back frames with valid held high on the GAP=0 instance
    base0 = strobes[0];
    frame_d[0] = {NUM_CH{16'hAAAA}};
    valid_d[0] = 1'b1;
    step();
    frame_d[0] = {NUM_CH{16'h5555}};
    run(22);
    valid_d[0] = 1'b0;
    run(25);
    chk("b2b.strobes", 32'(strobes[0] - base0), 32'd44);
    chk("b2b.cnt", 32'(cnt_o[0]), 32'd3);

    // Enable low blocks accepts; dropping it mid-frame lets the frame finish
    en_d = 2'b00;
    valid_d = 2'b11;
    rand_frame(0);
    rand_frame(1);
    base0 = strobes[0];
    run(30);
    chk("en_off.strobes", 32'(strobes[0] - base0), 32'd0);
    en_d = 2'b11;
    valid_d = 2'b00;
    step();
    rand_frame(0);
    valid_d[0] = 1'b1;
    step();
    valid_d[0] = 1'b0;
    run(10);
    chk("en_drop.ch10", 32'(ch_o[0]), 32'd10);
    en_d[0] = 1'b0;
    rand_frame(0);
    valid_d[0] = 1'b1;
    run(40);
    valid_d[0] = 1'b0;
    en_d[0] = 1'b1;
    run(2);
    chk("en_drop.strobes", 32'(strobes[0] - base0), 32'd22);

    // Asynchronous reset in the middle of a frame
    rand_frame(0);
    valid_d[0] = 1'b1;
    step();
    valid_d[0] = 1'b0;
    run(7);
    chk("rst.pre_ch", 32'(ch_o[0]), 32'd7);
    rst_n = 1'b0;
    #1;
    chk("rst.valid", 32'(vld_o[0]), 32'd0);
    chk("rst.data", 32'(dat_o[0]), 32'd0);
    chk("rst.ch", 32'(ch_o[0]), 32'd0);
    chk("rst.busy", 32'(busy_o[0]), 32'd0);
    chk("rst.cnt", 32'(cnt_o[0]), 32'd0);
    chk("rst.ready", 32'(rdy_o[0]), 32'd1);
    model_reset();
    @(negedge clk);
    cyc++;
    step();
    rst_n = 1'b1;
    step();
    rand_frame(0);
    valid_d[0] = 1'b1;
    step();
    valid_d[0] = 1'b0;
    run(30);
    chk("rst.cnt_after", 32'(cnt_o[0]), 32'd1);

    // Frame counter wrap from 0xFFFE through two back-to-back frames
    force u_dut0.cnt_q = 16'hFFFE;
    #1;
    release u_dut0.cnt_q;
    cnt_m[0] = 16'hFFFE;
    rand_frame(0);
    valid_d[0] = 1'b1;
    step();
    rand_frame(0);
    run(22);
    valid_d[0] = 1'b0;
    run(25);
    chk("wrap.cnt", 32'(cnt_o[0]), 32'd0);

    // Randomized traffic on both instances
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        en_d[i]    = ($urandom_range(0, 9) != 0);
        valid_d[i] = $urandom_range(0, 1) == 1;
        if ($urandom_range(0, 3) == 0) rand_frame(i);
      end
      step();
    end
    valid_d = 2'b00;
    en_d = 2'b11;
    run(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
